// File: rtl/or_rn_2ph_sync.sv
// or_rn_2ph_sync: N-port 2-phase request merge with OR or round-robin single-grant mode
module or_rn_2ph_sync #(
  parameter int N = 4,
  parameter int SYNC_STAGES = 2,
  parameter int MODE = 0
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] r_in,
  output logic [N-1:0] a_out,
  output logic         r,
  input  logic         a,
  output logic [N-1:0] grant,
  output logic         busy
);
  localparam int PW = $clog2(N);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;
  logic [N-1:0] r_s, pending, sel;
  logic a_s;
  logic [0:0] state;
  logic [PW-1:0] ptr, ptr_nxt;
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign r_s = r_in;
      assign a_s = a;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0][N:0] sr;
      always_ff @(posedge clk) begin
        if (!rstn) sr <= '0;
        else begin
          sr[0] <= {a, r_in};
          for (int i = 1; i < SYNC_STAGES; i++) sr[i] <= sr[i-1];
        end
      end
      assign {a_s, r_s} = sr[SYNC_STAGES-1];
    end
  endgenerate
  assign pending = r_s ^ a_out;
  assign busy = state;
  // Scan from the farthest offset down so the nearest pending port at or after ptr wins.
  always_comb begin
    int j;
    j = 0;
    sel = '0;
    ptr_nxt = ptr;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (pending[j]) begin
        sel = '0;
        sel[j] = 1'b1;
        ptr_nxt = PW'((j + 1) % N);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      r <= 1'b0;
      a_out <= '0;
      grant <= '0;
      ptr <= '0;
    end else if (state == IDLE) begin
      if (|pending) begin
        grant <= (MODE != 0) ? sel : pending;
        ptr <= ptr_nxt;
        r <= ~r;
        state <= WAIT;
      end
    end else if (a_s == r) begin
      a_out <= a_out ^ grant;
      grant <= '0;
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_or_rn_2ph_sync.sv
// tb_or_rn_2ph_sync: directed and randomized transaction-level checks on three configurations
module tb_or_rn_2ph_sync;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn;
  logic [3:0] rin [3];
  logic ain [3];
  logic [3:0] aout [3];
  logic [3:0] gnt [3];
  logic rr [3];
  logic bsy [3];
  int n_chk = 0;
  int n_fail = 0;
  logic [3:0] m_ao [3];
  logic m_r [3];
  int m_ptr [3];
  int cfg_mode [3] = '{0, 1, 0};
  int cfg_sync [3] = '{2, 2, 0};
  or_rn_2ph_sync #(.N(4), .SYNC_STAGES(2), .MODE(0)) d0 (
    .clk(clk), .rstn(rstn), .r_in(rin[0]), .a_out(aout[0]), .r(rr[0]), .a(ain[0]), .grant(gnt[0]), .busy(bsy[0]));
  or_rn_2ph_sync #(.N(4), .SYNC_STAGES(2), .MODE(1)) d1 (
    .clk(clk), .rstn(rstn), .r_in(rin[1]), .a_out(aout[1]), .r(rr[1]), .a(ain[1]), .grant(gnt[1]), .busy(bsy[1]));
  or_rn_2ph_sync #(.N(4), .SYNC_STAGES(0), .MODE(0)) d2 (
    .clk(clk), .rstn(rstn), .r_in(rin[2]), .a_out(aout[2]), .r(rr[2]), .a(ain[2]), .grant(gnt[2]), .busy(bsy[2]));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model_clear();
    for (int d = 0; d < 3; d++) begin
      m_ao[d] = '0;
      m_r[d] = 1'b0;
      m_ptr[d] = 0;
    end
  endtask
  task automatic wait_r(input int d, output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (rr[d] === m_r[d] && lat < 40);
    chk("r_toggle", rr[d] !== m_r[d], 1);
    m_r[d] = ~m_r[d];
  endtask
  task automatic wait_ack(input int d, output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (aout[d] === m_ao[d] && lat < 40);
  endtask
  // Grant expected by round-robin: nearest outstanding port at or after the pointer.
  function automatic logic [3:0] rr_pick(input logic [3:0] out, input int p);
    for (int k = 0; k < 4; k++)
      if (out[(p + k) % 4]) return 4'(1 << ((p + k) % 4));
    return 4'b0;
  endfunction
  task automatic serve(input int d, input logic [3:0] subset);
    logic [3:0] out, exp;
    int lat;
    bit first;
    rin[d] = rin[d] ^ subset;
    out = subset;
    first = 1;
    while (out != 0) begin
      exp = (cfg_mode[d] != 0) ? rr_pick(out, m_ptr[d]) : out;
      wait_r(d, lat);
      chk("req_lat", lat, first ? cfg_sync[d] + 1 : 1);
      chk("grant", gnt[d], exp);
      chk("busy_hi", bsy[d], 1);
      repeat ($urandom_range(0, 3)) tick();
      ain[d] = ~ain[d];
      wait_ack(d, lat);
      chk("ack_lat", lat, cfg_sync[d] + 1);
      chk("a_out", aout[d], m_ao[d] ^ exp);
      chk("grant_clr", gnt[d], 0);
      chk("busy_lo", bsy[d], 0);
      m_ao[d] = m_ao[d] ^ exp;
      out = out & ~exp;
      if (cfg_mode[d] != 0)
        for (int i = 0; i < 4; i++) if (exp[i]) m_ptr[d] = (i + 1) % 4;
      first = 0;
    end
  endtask
  initial begin
    int lat;
    bit spurious;
    rstn = 1'b0;
    for (int d = 0; d < 3; d++) begin
      rin[d] = '0;
      ain[d] = 1'b0;
    end
    model_clear();
    repeat (3) tick();
    for (int d = 0; d < 3; d++) begin
      chk("rst_r", rr[d], 0);
      chk("rst_aout", aout[d], 0);
      chk("rst_grant", gnt[d], 0);
      chk("rst_busy", bsy[d], 0);
    end
    rstn = 1'b1;
    tick();
    serve(0, 4'b0100);
    serve(0, 4'b1011);
    rin[0][0] = ~rin[0][0];
    wait_r(0, lat);
    chk("late_lat", lat, 3);
    chk("late_grant0", gnt[0], 4'b0001);
    rin[0][1] = ~rin[0][1];
    repeat (4) tick();
    chk("late_hold", gnt[0], 4'b0001);
    ain[0] = ~ain[0];
    wait_ack(0, lat);
    chk("late_aout0", aout[0], m_ao[0] ^ 4'b0001);
    m_ao[0] = m_ao[0] ^ 4'b0001;
    wait_r(0, lat);
    chk("late_lat2", lat, 1);
    chk("late_grant1", gnt[0], 4'b0010);
    ain[0] = ~ain[0];
    wait_ack(0, lat);
    chk("late_aout1", aout[0], m_ao[0] ^ 4'b0010);
    m_ao[0] = m_ao[0] ^ 4'b0010;
    serve(1, 4'b1111);
    serve(1, 4'b1001);
    serve(2, 4'b0010);
    rin[0] = rin[0] ^ 4'b0110;
    wait_r(0, lat);
    chk("mid_grant", gnt[0], 4'b0110);
    rstn = 1'b0;
    for (int d = 0; d < 3; d++) begin
      rin[d] = '0;
      ain[d] = 1'b0;
    end
    tick();
    chk("mid_r", rr[0], 0);
    chk("mid_aout", aout[0], 0);
    chk("mid_grant_clr", gnt[0], 0);
    chk("mid_busy", bsy[0], 0);
    rstn = 1'b1;
    model_clear();
    spurious = 0;
    repeat (10) begin
      tick();
      if (rr[0] || rr[1] || rr[2]) spurious = 1;
    end
    chk("no_spurious", spurious, 0);
    for (int d = 0; d < 3; d++)
      repeat (8) serve(d, 4'($urandom_range(1, 15)));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/or_rn_2ph_sync.md
# or_rn_2ph_sync

Clocked, parametrised N-port merge of 2-phase (transition-signalling) request channels onto one 2-phase output channel. It generalises the two-port asynchronous request-OR to N ports and adds an arbitrated single-grant mode. It sits at the boundary between self-timed request sources and a clocked consumer, and synchronises all incoming handshake wires internally.

## Interface
- N, 4, number of input request ports (2..16)
- SYNC_STAGES, 2, synchroniser flops on every incoming handshake wire (0 = inputs already synchronous)
- MODE, 0, 0 = OR mode (all pending ports served by one output transaction); 1 = arbitrated mode (one port per transaction, round-robin)

- clk  input  1  sole clock, rising edge
- rstn  input  1  reset, synchronous, active-low
- r_in  input  N  per-port 2-phase request; a toggle means "request"
- a_out  output  N  per-port 2-phase acknowledge; a toggle completes that port's handshake
- r  output  1  merged 2-phase request to consumer
- a  input  1  2-phase acknowledge from consumer
- grant  output  N  ports served by the transaction in flight; 0 when idle
- busy  output  1  high while an output transaction is in flight (r != synchronised a)

## Operation
- Each of r_in[i] and a passes through SYNC_STAGES flops, giving r_s[i] and a_s. All decisions use the synchronised values.
- pending[i] = r_s[i] XOR a_out[i]. A port is pending between its request toggle and its acknowledge toggle.
- FSM with two states.
  - IDLE: if pending != 0, load grant, toggle r, go to WAIT. Otherwise hold.
  - WAIT: when a_s == r, toggle a_out[i] for every set bit of grant, clear grant, go to IDLE.
- Grant selection:
  - MODE 0: grant = pending, as sampled in the IDLE cycle.
  - MODE 1: grant = one-hot, selecting the lowest pending index at or above ptr, wrapping modulo N. On grant, ptr becomes granted index + 1, modulo N.
- A port that becomes pending while in WAIT is not added to grant. It is served by a later transaction.
- A port acknowledged in a WAIT→IDLE cycle is not pending in the following IDLE cycle, because a_out and grant update together. There is no double service.
- Requester contract: do not toggle r_in[i] again before a_out[i] toggles. Consumer contract: toggle a exactly once per r toggle. A violation need not be flagged, but the FSM must not lock up; it always returns to IDLE once a_s == r.
- Reset (rstn low at a clk edge, any state): r=0, a_out=0, grant=0, busy=0, ptr=0, all synchroniser flops 0, state IDLE. Sources must return r_in and a to 0 during reset. Reset mid-transaction abandons the transaction with no ack toggles.

## Timing
- All outputs are registered.
- Latency from r_in[i] toggle to r toggle: SYNC_STAGES+1 clk edges, when idle.
- Latency from a toggle to a_out toggle: SYNC_STAGES+1 clk edges.
- busy rises on the same edge r toggles. It falls on the same edge a_out toggles.
- Back-to-back transactions: minimum 1 IDLE cycle between the a_out toggle and the next r toggle.
- Simultaneous request toggles on several ports in the same cycle:
  - MODE 0: one transaction serves all of them.
  - MODE 1: one transaction per port, in round-robin order from ptr.
- A request toggle arriving on the same cycle as the WAIT→IDLE transition is captured on the next IDLE cycle.

## Test plan
- Reset, then single request (N=4, SYNC_STAGES=2, MODE 0): toggle r_in[2] → r toggles 3 edges later and grant=0100. Toggle a → a_out[2] toggles 3 edges later; grant=0 and busy=0 at that edge.
- OR merge (MODE 0): toggle r_in[0], r_in[1], r_in[3] in the same cycle → exactly one r toggle with grant=1011. After one a toggle, a_out=1011 all toggle on the same edge.
- Late join (MODE 0): r_in[0] toggles; r_in[1] toggles while WAIT → first transaction grant=0001 only. After the a toggle, a second r toggle follows with grant=0010.
- Round-robin (MODE 1): all four ports pending with ptr=0 → grants 0001, 0010, 0100, 1000 in order. Then re-request port 0 and port 3 with ptr=0 → grant 0001 first.
- Reset mid-transaction: assert rstn=0 while in WAIT with grant=0110 → next edge r=0, a_out=0, grant=0, busy=0. After release with inputs at 0, no spurious r toggle within 10 cycles.
- SYNC_STAGES=0: toggle r_in[1] → r toggles on the next edge; toggle a → a_out[1] toggles on the next edge.
